// File: rtl/rr_src_arbiter8_pkg.sv
// rr_src_arbiter8_pkg: shared state encodings and source index width
package rr_src_arbiter8_pkg;
  localparam int SRC_BITS = 3;
  localparam logic [1:0] IDLE = 2'b00, CAPTURE = 2'b01, HOLD = 2'b10;
endpackage

// File: rtl/rr_src_arbiter8_pick.sv
// rr_pick8: combinational rotate-priority finder, first set req bit at or after ptr
module rr_pick8
  import rr_src_arbiter8_pkg::*;
(
  input  logic [7:0]          req,
  input  logic [SRC_BITS-1:0] ptr,
  output logic                any,
  output logic [SRC_BITS-1:0] idx
);
  logic [15:0] dbl;
  logic [SRC_BITS-1:0] off;
  assign dbl = {req, req} >> ptr;
  assign any = |req;
  assign idx = ptr + off;
  always_comb begin
    off = '0;
    for (int k = 7; k >= 0; k--) if (dbl[k]) off = k[SRC_BITS-1:0];
  end
endmodule

// File: rtl/rr_src_arbiter8.sv
// rr_src_arbiter8: round-robin source arbiter driving a mux8 select and capturing its output
module rr_src_arbiter8
  import rr_src_arbiter8_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          req,
  output logic [SRC_BITS-1:0] sel,
  input  logic [WIDTH-1:0]    mux_y,
  output logic [7:0]          ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SRC_BITS-1:0] out_src
);
  logic [1:0] state;
  logic [SRC_BITS-1:0] ptr, idx;
  logic any, take;
  rr_pick8 u_pick (.req(req), .ptr(ptr), .any(any), .idx(idx));
  assign take = state == CAPTURE && req[sel];
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= '0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else begin
      ack <= take ? 8'd1 << sel : 8'd0;
      case (state)
        IDLE: if (any) begin
          sel   <= idx;
          state <= CAPTURE;
        end
        CAPTURE: begin
          state <= take ? HOLD : IDLE;
          if (take) begin
            out_data  <= mux_y;
            out_src   <= sel;
            out_valid <= 1'b1;
            ptr       <= sel + 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_src_arbiter8.sv
// tb_rr_src_arbiter8: randomized self-checking bench with a transaction-level round-robin model
module tb_rr_src_arbiter8;
  logic clk = 0, reset = 1, out_ready = 0;
  logic [7:0] req = 0, ack;
  logic [2:0] sel, out_src;
  logic [15:0] mux_y, out_data;
  logic out_valid;
  logic [15:0] d [8];
  int n_pass = 0, n_total = 0, mptr = 0;
  always #5 clk = ~clk;
  assign mux_y = d[sel];
  rr_src_arbiter8 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req(req), .sel(sel), .mux_y(mux_y), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );
  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain;
    req = 0;
    out_ready = 1;
    repeat (3) tick();
  endtask
  task automatic pulse_reset;
    reset = 1;
    tick();
    reset = 0;
    mptr = 0;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 8; i++) d[i] = 16'h1000 + 16'(i);
    reset = 1;
    req = 8'hFF;
    out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if ({sel, ack, out_valid, out_data, out_src} !== 31'd0)
        $display("FAIL reset_state got sel=%0d ack=%h v=%b data=%h src=%0d want all 0", sel, ack, out_valid, out_data, out_src);
      else n_pass++;
    end
    reset = 0;
    mptr = 0;
    tick();
    n_total++;
    if (sel !== 3'd0) $display("FAIL reset_first_sel got %0d want 0", sel); else n_pass++;
    tick();
    n_total++;
    if (ack !== 8'h01 || out_src !== 3'd0 || out_data !== 16'h1000)
      $display("FAIL reset_first_grant got ack=%h src=%0d data=%h want 01 0 1000", ack, out_src, out_data);
    else n_pass++;
    mptr = 1;
    drain();
  endtask
  task automatic test_single;
    d[3] = 16'hBEEF;
    req = 8'h08;
    out_ready = 1;
    tick();
    n_total++;
    if (sel !== 3'd3 || ack !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL single_sel got sel=%0d ack=%h v=%b want 3 00 0", sel, ack, out_valid);
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_src !== 3'd3 || ack !== 8'h08)
      $display("FAIL single_capture got v=%b data=%h src=%0d ack=%h want 1 beef 3 08", out_valid, out_data, out_src, ack);
    else n_pass++;
    tick();
    n_total++;
    if (ack !== 8'h00 || out_valid !== 1'b0)
      $display("FAIL single_ack_pulse got ack=%h v=%b want 00 0", ack, out_valid);
    else n_pass++;
    req = 0;
    mptr = 4;
    drain();
  endtask
  task automatic test_round_robin;
    int cyc, exp;
    logic found;
    logic [7:0] oh;
    for (int i = 0; i < 8; i++) d[i] = 16'h1000 + 16'(i);
    pulse_reset();
    req = 8'hFF;
    out_ready = 1;
    for (int w = 0; w < 9; w++) begin
      cyc = 0;
      found = 0;
      for (int c = 0; c < 6 && !found; c++) begin
        tick();
        cyc++;
        if (ack !== 8'h00) found = 1;
      end
      exp = pick(8'hFF, mptr);
      oh = 8'd1 << exp;
      n_total++;
      if (!found) $display("FAIL rr_timeout word %0d no ack within 6 cycles", w); else n_pass++;
      n_total++;
      if (out_src !== 3'(exp) || out_data !== 16'h1000 + 16'(exp) || ack !== oh || exp != w % 8)
        $display("FAIL rr_word %0d got src=%0d data=%h ack=%h want %0d %h %h", w, out_src, out_data, ack, w % 8, 16'h1000 + 16'(w % 8), oh);
      else n_pass++;
      if (w > 0) begin
        n_total++;
        if (cyc != 3) $display("FAIL rr_spacing word %0d got %0d cycles want 3", w, cyc); else n_pass++;
      end
      mptr = (exp + 1) % 8;
    end
    drain();
  endtask
  task automatic test_backpressure;
    logic [15:0] w;
    w = 16'($urandom);
    d[6] = w;
    req = 8'h40;
    out_ready = 0;
    tick();
    tick();
    n_total++;
    if (ack !== 8'h40 || out_valid !== 1'b1 || out_data !== w)
      $display("FAIL bp_capture got ack=%h v=%b data=%h want 40 1 %h", ack, out_valid, out_data, w);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== w || out_src !== 3'd6 || sel !== 3'd6 || ack !== 8'h00)
        $display("FAIL bp_stable cycle %0d got v=%b data=%h src=%0d sel=%0d ack=%h want 1 %h 6 6 00", c, out_valid, out_data, out_src, sel, ack, w);
      else n_pass++;
    end
    out_ready = 1;
    tick();
    req = 0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL bp_accept got v=%b want 0", out_valid); else n_pass++;
    mptr = 7;
    drain();
  endtask
  task automatic test_withdraw;
    pulse_reset();
    req = 8'h20;
    out_ready = 1;
    tick();
    n_total++;
    if (sel !== 3'd5) $display("FAIL wd_sel got %0d want 5", sel); else n_pass++;
    req = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if (ack !== 8'h00 || out_valid !== 1'b0)
        $display("FAIL wd_no_grant cycle %0d got ack=%h v=%b want 00 0", c, ack, out_valid);
      else n_pass++;
    end
    req = 8'h21;
    tick();
    n_total++;
    if (sel !== 3'd0) $display("FAIL wd_next_sel got %0d want 0", sel); else n_pass++;
    tick();
    n_total++;
    if (ack !== 8'h01 || out_src !== 3'd0 || out_data !== d[0])
      $display("FAIL wd_next_grant got ack=%h src=%0d data=%h want 01 0 %h", ack, out_src, out_data, d[0]);
    else n_pass++;
    mptr = 1;
    drain();
  endtask
  task automatic test_reset_hold;
    req = 8'h10;
    out_ready = 0;
    tick();
    tick();
    n_total++;
    if (out_valid !== 1'b1 || ack !== 8'h10)
      $display("FAIL rh_capture got v=%b ack=%h want 1 10", out_valid, ack);
    else n_pass++;
    req = 0;
    reset = 1;
    tick();
    n_total++;
    if (out_valid !== 1'b0 || ack !== 8'h00 || sel !== 3'd0)
      $display("FAIL rh_reset got v=%b ack=%h sel=%0d want 0 00 0", out_valid, ack, sel);
    else n_pass++;
    reset = 0;
    mptr = 0;
    req = 8'h81;
    out_ready = 1;
    tick();
    n_total++;
    if (sel !== 3'd0) $display("FAIL rh_next_sel got %0d want 0", sel); else n_pass++;
    tick();
    n_total++;
    if (ack !== 8'h01 || out_src !== 3'd0)
      $display("FAIL rh_next_grant got ack=%h src=%0d want 01 0", ack, out_src);
    else n_pass++;
    mptr = 1;
    drain();
  endtask
  task automatic test_random;
    int exp, cyc, n;
    logic found;
    logic [7:0] r, oh;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
      r = 8'($urandom_range(1, 255));
      exp = pick(r, mptr);
      oh = 8'd1 << exp;
      req = r;
      out_ready = 0;
      cyc = 0;
      found = 0;
      for (int c = 0; c < 4 && !found; c++) begin
        tick();
        cyc++;
        if (ack !== 8'h00) found = 1;
      end
      n_total++;
      if (!found || cyc != 2) $display("FAIL rnd_latency txn %0d got found=%b cycles=%0d want 1 2", t, found, cyc); else n_pass++;
      n_total++;
      if (ack !== oh || out_src !== 3'(exp) || out_data !== d[exp] || out_valid !== 1'b1)
        $display("FAIL rnd_grant txn %0d req=%h got ack=%h src=%0d data=%h v=%b want %h %0d %h 1", t, r, ack, out_src, out_data, out_valid, oh, exp, d[exp]);
      else n_pass++;
      n = $urandom_range(0, 3);
      for (int c = 0; c < n; c++) begin
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 3'(exp) || ack !== 8'h00)
          $display("FAIL rnd_hold txn %0d got v=%b src=%0d ack=%h want 1 %0d 00", t, out_valid, out_src, ack, exp);
        else n_pass++;
      end
      out_ready = 1;
      tick();
      req = 0;
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rnd_accept txn %0d got v=%b want 0", t, out_valid); else n_pass++;
      mptr = (exp + 1) % 8;
    end
    drain();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_reset_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
